// File: rtl/vxe_vpu_cmd_dispatch_pkg.sv
// Types and widths for the VPU command dispatcher.
`include "vxe_vpu_cmd_defs.vh"

package vxe_vpu_cmd_dispatch_pkg;

  localparam int CMD_OP_W = `VXE_CMD_OP_W;
  localparam int CMD_TH_W = `VXE_CMD_TH_W;
  localparam int CMD_PL_W = `VXE_CMD_PL_W;
  localparam int CMD_W    = CMD_OP_W + CMD_TH_W + CMD_PL_W;

  // One command as held while it is being delivered to the VPUs.
  typedef struct packed {
    logic [CMD_OP_W-1:0] op;
    logic [CMD_TH_W-1:0] th;
    logic [CMD_PL_W-1:0] pl;
  } cmd_t;

endpackage

// File: rtl/vxe_sat_counter.sv
// Saturating up-counter with a synchronous clear; clear wins over increment.
module vxe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == {WIDTH{1'b1}});
  assign o_cnt    = r_cnt;

  // Count up on i_inc, hold at all-ones, clear on reset or i_clr.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vxe_vpu_cmd_defs.vh
// Command field widths shared by the VPU command dispatcher and the VPU
// command queue, so both ends of the sel/ack interface agree on widths.
`ifndef VXE_VPU_CMD_DEFS_VH
`define VXE_VPU_CMD_DEFS_VH

`define VXE_CMD_OP_W 5
`define VXE_CMD_TH_W 3
`define VXE_CMD_PL_W 48

`endif

// File: rtl/vxe_vpu_cmd_dispatch.sv
// Transmit side of the VPU command interface. Holds one command and presents
// it to every VPU named in its destination mask; the command retires only once
// all of those VPUs have acked, which keeps command order identical across VPUs.
//
// Handshakes:
//  - Upstream: a command transfers on a cycle with i_vld && o_rdy. o_rdy is a
//    function of the pending mask and i_cmd_ack only (never of i_vld), so a
//    command can be accepted in the same cycle the last owed ack arrives.
//  - Downstream: VPU n takes the command on a cycle with o_cmd_sel[n] &&
//    i_cmd_ack[n]. o_cmd_sel is registered; an acked bit drops the next cycle
//    and the shared op/th/pl stay unchanged while any bit is still pending.
//    Acks on bits that are not pending are ignored.
module vxe_vpu_cmd_dispatch
  import vxe_vpu_cmd_dispatch_pkg::*;
#(
  parameter int NR_VPUS = 2,
  parameter int STALL_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_vld,
  output logic                o_rdy,
  input  logic [NR_VPUS-1:0]  i_dst,
  input  logic [CMD_OP_W-1:0] i_op,
  input  logic [CMD_TH_W-1:0] i_th,
  input  logic [CMD_PL_W-1:0] i_pl,
  output logic [NR_VPUS-1:0]  o_cmd_sel,
  input  logic [NR_VPUS-1:0]  i_cmd_ack,
  output logic [CMD_OP_W-1:0] o_cmd_op,
  output logic [CMD_TH_W-1:0] o_cmd_th,
  output logic [CMD_PL_W-1:0] o_cmd_pl,
  output logic                o_busy,
  output logic [STALL_W-1:0]  o_stall_cnt,
  input  logic                i_stall_clr
);

  cmd_t               r_cmd;
  logic [NR_VPUS-1:0] r_pend;

  logic [NR_VPUS-1:0] w_owed;
  logic               w_done;
  logic               w_take;
  logic               w_stall;

  // VPUs that remain owed the held command after this cycle's acks.
  assign w_owed  = r_pend & ~i_cmd_ack;
  assign w_done  = (w_owed == '0);
  assign w_take  = i_vld && w_done;
  assign w_stall = |w_owed;

  assign o_rdy     = w_done;
  assign o_cmd_sel = r_pend;
  assign o_busy    = |r_pend;
  assign o_cmd_op  = r_cmd.op;
  assign o_cmd_th  = r_cmd.th;
  assign o_cmd_pl  = r_cmd.pl;

  // Load a new command and its mask on transfer; otherwise retire acked bits.
  // A zero mask loads nothing pending, so that command is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_cmd  <= '0;
    end else if (w_take) begin
      r_pend <= i_dst;
      r_cmd  <= '{op: i_op, th: i_th, pl: i_pl};
    end else begin
      r_pend <= w_owed;
    end
  end

  vxe_sat_counter #(
    .WIDTH (STALL_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall),
    .i_clr (i_stall_clr),
    .o_cnt (o_stall_cnt)
  );

endmodule

// File: tb/tb_vxe_vpu_cmd_dispatch.sv
// Bench for vxe_vpu_cmd_dispatch: reset, table-driven directed vectors,
// stall counter saturation, and a randomized per-VPU ordering scoreboard.
module tb_vxe_vpu_cmd_dispatch;

  localparam int NR      = 2;
  localparam int SW      = 4;
  localparam int N_CMDS  = 1000;

  logic          clk;
  logic          rst;
  logic          i_vld;
  logic          o_rdy;
  logic [NR-1:0] i_dst;
  logic [4:0]    i_op;
  logic [2:0]    i_th;
  logic [47:0]   i_pl;
  logic [NR-1:0] o_cmd_sel;
  logic [NR-1:0] i_cmd_ack;
  logic [4:0]    o_cmd_op;
  logic [2:0]    o_cmd_th;
  logic [47:0]   o_cmd_pl;
  logic          o_busy;
  logic [SW-1:0] o_stall_cnt;
  logic          i_stall_clr;

  int total = 0;
  int bad   = 0;

  // Per-VPU expected command streams, {op,th,pl}.
  logic [55:0] exp_q0[$];
  logic [55:0] exp_q1[$];
  logic [NR-1:0] mpend = '0;
  int n_acc = 0;

  vxe_vpu_cmd_dispatch #(
    .NR_VPUS (NR),
    .STALL_W (SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_vld       (i_vld),
    .o_rdy       (o_rdy),
    .i_dst       (i_dst),
    .i_op        (i_op),
    .i_th        (i_th),
    .i_pl        (i_pl),
    .o_cmd_sel   (o_cmd_sel),
    .i_cmd_ack   (i_cmd_ack),
    .o_cmd_op    (o_cmd_op),
    .o_cmd_th    (o_cmd_th),
    .o_cmd_pl    (o_cmd_pl),
    .o_busy      (o_busy),
    .o_stall_cnt (o_stall_cnt),
    .i_stall_clr (i_stall_clr)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish, act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle at the negedge, then leave 1ns for outputs to settle.
  task automatic apply(input logic r, input logic vld, input logic [1:0] dst,
                       input logic [4:0] op, input logic [1:0] ack, input logic clr);
    @(negedge clk);
    rst         = r;
    i_vld       = vld;
    i_dst       = dst;
    i_op        = op;
    i_th        = op[2:0];
    i_pl        = 48'(op) * 48'h1111;
    i_cmd_ack   = ack;
    i_stall_clr = clr;
    #1;
  endtask

  // Random cycle with scoreboard: deliveries popped, acceptances pushed.
  task automatic rand_cycle(input logic want, input logic [1:0] ack);
    logic [55:0] cmd;
    logic [55:0] got;
    logic [55:0] exp;
    logic        e_rdy;
    cmd = {5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
           16'($urandom), 32'($urandom)};
    @(negedge clk);
    rst         = 1'b0;
    i_stall_clr = 1'b0;
    i_vld       = want;
    i_dst       = 2'($urandom_range(0, 3));
    {i_op, i_th, i_pl} = cmd;
    i_cmd_ack   = ack;
    #1;
    e_rdy = ((mpend & ~ack) == 2'b00);
    chk("rnd_sel", 64'(o_cmd_sel), 64'(mpend));
    chk("rnd_rdy", 64'(o_rdy), 64'(e_rdy));
    got = {o_cmd_op, o_cmd_th, o_cmd_pl};
    if (mpend[0] && ack[0]) begin
      if (exp_q0.size() == 0) begin
        total++; bad++;
        $display("FAIL rnd_vpu0_underflow act=%0h exp=none", got);
      end else begin
        exp = exp_q0.pop_front();
        chk("rnd_vpu0_data", 64'(got), 64'(exp));
      end
    end
    if (mpend[1] && ack[1]) begin
      if (exp_q1.size() == 0) begin
        total++; bad++;
        $display("FAIL rnd_vpu1_underflow act=%0h exp=none", got);
      end else begin
        exp = exp_q1.pop_front();
        chk("rnd_vpu1_data", 64'(got), 64'(exp));
      end
    end
    if (want && e_rdy) begin
      if (i_dst[0]) exp_q0.push_back(cmd);
      if (i_dst[1]) exp_q1.push_back(cmd);
      mpend = i_dst;
      n_acc++;
    end else begin
      mpend = mpend & ~ack;
    end
  endtask

  typedef struct {
    logic       vld;
    logic [1:0] dst;
    logic [4:0] op;
    logic [1:0] ack;
    logic [1:0] e_sel;
    logic       e_rdy;
    logic       e_busy;
    logic [3:0] e_cnt;
    logic       chk_op;
    logic [4:0] e_op;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int cyc;

    // Back-to-back with acks tied high: one command per cycle.
    tbl[0]  = '{1'b1, 2'b11, 5'd1,  2'b11, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 5'd0};
    tbl[1]  = '{1'b1, 2'b11, 5'd2,  2'b11, 2'b11, 1'b1, 1'b1, 4'd0, 1'b1, 5'd1};
    tbl[2]  = '{1'b1, 2'b11, 5'd3,  2'b11, 2'b11, 1'b1, 1'b1, 4'd0, 1'b1, 5'd2};
    tbl[3]  = '{1'b0, 2'b11, 5'd0,  2'b11, 2'b11, 1'b1, 1'b1, 4'd0, 1'b1, 5'd3};
    tbl[4]  = '{1'b0, 2'b00, 5'd0,  2'b00, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 5'd0};
    // Partial ack: VPU0 first, VPU1 a cycle later; one stall cycle.
    tbl[5]  = '{1'b1, 2'b11, 5'h0A, 2'b00, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 5'd0};
    tbl[6]  = '{1'b0, 2'b00, 5'd0,  2'b01, 2'b11, 1'b0, 1'b1, 4'd0, 1'b1, 5'h0A};
    tbl[7]  = '{1'b0, 2'b00, 5'd0,  2'b10, 2'b10, 1'b1, 1'b1, 4'd1, 1'b1, 5'h0A};
    tbl[8]  = '{1'b0, 2'b00, 5'd0,  2'b00, 2'b00, 1'b1, 1'b0, 4'd1, 1'b0, 5'd0};
    // Zero mask is dropped; the next command is taken the following cycle.
    tbl[9]  = '{1'b1, 2'b00, 5'd7,  2'b00, 2'b00, 1'b1, 1'b0, 4'd1, 1'b0, 5'd0};
    tbl[10] = '{1'b1, 2'b01, 5'd8,  2'b00, 2'b00, 1'b1, 1'b0, 4'd1, 1'b0, 5'd0};
    tbl[11] = '{1'b0, 2'b00, 5'd0,  2'b01, 2'b01, 1'b1, 1'b1, 4'd1, 1'b1, 5'd8};
    tbl[12] = '{1'b0, 2'b00, 5'd0,  2'b00, 2'b00, 1'b1, 1'b0, 4'd1, 1'b0, 5'd0};

    rst = 1'b1; i_vld = 1'b0; i_dst = '0; i_op = '0; i_th = '0; i_pl = '0;
    i_cmd_ack = '0; i_stall_clr = 1'b0;

    // Reset, then reset again in the middle of a two-VPU delivery.
    apply(1'b1, 1'b0, 2'b00, 5'd0, 2'b00, 1'b0);
    apply(1'b1, 1'b0, 2'b00, 5'd0, 2'b00, 1'b0);
    apply(1'b0, 1'b1, 2'b11, 5'd5, 2'b00, 1'b0);
    chk("rst_sel",  64'(o_cmd_sel),   64'(0));
    chk("rst_rdy",  64'(o_rdy),       64'(1));
    chk("rst_busy", 64'(o_busy),      64'(0));
    chk("rst_cnt",  64'(o_stall_cnt), 64'(0));
    chk("rst_op",   64'(o_cmd_op),    64'(0));
    apply(1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 1'b0);
    chk("pre_sel", 64'(o_cmd_sel), 64'(2'b11));
    chk("pre_rdy", 64'(o_rdy),     64'(0));
    apply(1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 1'b0);
    chk("pre_cnt", 64'(o_stall_cnt), 64'(1));
    apply(1'b1, 1'b0, 2'b00, 5'd0, 2'b00, 1'b0);
    chk("pre_cnt2", 64'(o_stall_cnt), 64'(2));
    apply(1'b1, 1'b0, 2'b00, 5'd0, 2'b00, 1'b0);
    chk("midrst1_sel", 64'(o_cmd_sel), 64'(0));
    apply(1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 1'b0);
    chk("midrst_sel",  64'(o_cmd_sel),   64'(0));
    chk("midrst_rdy",  64'(o_rdy),       64'(1));
    chk("midrst_busy", 64'(o_busy),      64'(0));
    chk("midrst_cnt",  64'(o_stall_cnt), 64'(0));

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      apply(1'b0, tbl[i].vld, tbl[i].dst, tbl[i].op, tbl[i].ack, 1'b0);
      chk($sformatf("vec%0d_sel", i),  64'(o_cmd_sel),   64'(tbl[i].e_sel));
      chk($sformatf("vec%0d_rdy", i),  64'(o_rdy),       64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_busy", i), 64'(o_busy),      64'(tbl[i].e_busy));
      chk($sformatf("vec%0d_cnt", i),  64'(o_stall_cnt), 64'(tbl[i].e_cnt));
      if (tbl[i].chk_op) begin
        chk($sformatf("vec%0d_op", i), 64'(o_cmd_op), 64'(tbl[i].e_op));
        chk($sformatf("vec%0d_pl", i), 64'(o_cmd_pl), 64'(48'(tbl[i].e_op) * 48'h1111));
      end
    end

    // Stall counter saturation and clear.
    apply(1'b0, 1'b1, 2'b01, 5'd9, 2'b00, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      apply(1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 1'b0);
    end
    chk("sat_cnt", 64'(o_stall_cnt), 64'(15));
    chk("sat_sel", 64'(o_cmd_sel),   64'(2'b01));
    chk("sat_op",  64'(o_cmd_op),    64'(9));
    apply(1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 1'b1);
    chk("clr_pre_cnt", 64'(o_stall_cnt), 64'(15));
    apply(1'b0, 1'b0, 2'b00, 5'd0, 2'b01, 1'b0);
    chk("clr_cnt", 64'(o_stall_cnt), 64'(0));
    chk("clr_rdy", 64'(o_rdy),       64'(1));
    apply(1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 1'b0);
    chk("clr_sel",  64'(o_cmd_sel),   64'(0));
    chk("clr_cnt2", 64'(o_stall_cnt), 64'(0));

    // Randomized ordering with destination and ack backpressure.
    mpend = '0;
    cyc   = 0;
    while (n_acc < N_CMDS && cyc < 20000) begin
      rand_cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
      cyc++;
    end
    chk("rnd_accepted", 64'(n_acc), 64'(N_CMDS));
    for (int k = 0; k < 4; k++) begin
      rand_cycle(1'b0, 2'b11);
    end
    chk("rnd_q0_empty", 64'(exp_q0.size()), 64'(0));
    chk("rnd_q1_empty", 64'(exp_q1.size()), 64'(0));
    chk("rnd_idle_busy", 64'(o_busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
